// File: rtl/pc_sequencer_ras.sv
// pc_sequencer_ras: PC register and next-PC selection for the multicycle core, with a
// circular return-address stack (RAS) for JAL-with-link / RET.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        synchronous active-high reset (overrides pc_en_i)
//   pc_en_i        commit strobe; PC, RAS and error flag update only when high
//   instruction_i  current instruction word (immediate offset fields in the low bits)
//   zero_flag_i    ALU zero result, qualifies BEQ
//   branch_i       BEQ control
//   jal_i          JAL control
//   link_i         with jal_i: push pc+1 on the RAS
//   ret_i          return: pop the RAS and jump to the popped address
//   pc_o           current PC (registered)
//   next_pc_o      combinational preview of the PC after the next commit
//   ras_empty_o    RAS holds no entries
//   ras_full_o     RAS holds RAS_DEPTH entries
//   ras_err_o      sticky overflow/underflow flag, cleared only by reset
module pc_sequencer_ras #(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned JAL_IMM_W = 9,
    parameter int unsigned BR_IMM_W  = 6,
    parameter int unsigned RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            pc_en_i,
    input  logic [15:0]     instruction_i,
    input  logic            zero_flag_i,
    input  logic            branch_i,
    input  logic            jal_i,
    input  logic            link_i,
    input  logic            ret_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] next_pc_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            ras_err_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  pc_q;
    logic [PTR_W-1:0] top_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];

    logic [PC_W-1:0]  pc_plus1;
    logic [PC_W-1:0]  jal_off;
    logic [PC_W-1:0]  br_off;
    logic [PC_W-1:0]  next_pc;
    logic [PTR_W-1:0] top_inc;
    logic             ras_empty;
    logic             ras_full;
    logic             push;

    assign pc_plus1 = pc_q + PC_W'(1);
    assign jal_off  = {{(PC_W - JAL_IMM_W){instruction_i[JAL_IMM_W-1]}},
                       instruction_i[JAL_IMM_W-1:0]};
    assign br_off   = {{(PC_W - BR_IMM_W){instruction_i[BR_IMM_W-1]}},
                       instruction_i[BR_IMM_W-1:0]};
    assign top_inc  = top_q + PTR_W'(1);

    // Flags come from the registered count only, so they never see the control inputs.
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    // ret takes priority over jal, so a simultaneous jal+link never pushes.
    assign push = jal_i & link_i & ~ret_i;

    always_comb begin
        next_pc = pc_plus1;
        if (ret_i) begin
            if (!ras_empty) begin
                next_pc = ras_q[top_q];
            end
        end else if (jal_i) begin
            next_pc = pc_q + jal_off;
        end else if (branch_i && zero_flag_i) begin
            next_pc = pc_q + br_off;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (pc_en_i) begin
            pc_q <= next_pc;
            if (ret_i) begin
                if (!ras_empty) begin
                    top_q <= top_q - PTR_W'(1);
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end else if (push) begin
                top_q <= top_inc;
                // When full the write at top+1 lands on the oldest entry.
                if (ras_full) begin
                    err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Entry storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && pc_en_i && push) begin
            ras_q[top_inc] <= pc_plus1;
        end
    end

    assign pc_o        = pc_q;
    assign next_pc_o   = next_pc;
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;
    assign ras_err_o   = err_q;

endmodule

// File: tb/tb_pc_sequencer_ras.sv
// tb_pc_sequencer_ras: directed stimulus with a queue-based reference model of the PC stage;
// a negedge process compares every output to the model, and literal checks pin key values.
module tb_pc_sequencer_ras;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en;
    logic [15:0] instruction;
    logic        zero_flag;
    logic        branch;
    logic        jal;
    logic        link;
    logic        ret;
    logic [15:0] pc;
    logic [15:0] next_pc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int          m_pc;
    int          m_stack[$];
    bit          m_err;

    always #5 clk = ~clk;

    pc_sequencer_ras dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .pc_en_i       (pc_en),
        .instruction_i (instruction),
        .zero_flag_i   (zero_flag),
        .branch_i      (branch),
        .jal_i         (jal),
        .link_i        (link),
        .ret_i         (ret),
        .pc_o          (pc),
        .next_pc_o     (next_pc),
        .ras_empty_o   (ras_empty),
        .ras_full_o    (ras_full),
        .ras_err_o     (ras_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_next();
        logic signed [8:0] jimm;
        logic signed [5:0] bimm;
        jimm = instruction[8:0];
        bimm = instruction[5:0];
        if (ret && m_stack.size() > 0) return m_stack[$];
        if (ret) return (m_pc + 1) & 16'hFFFF;
        if (jal) return (m_pc + int'(jimm)) & 16'hFFFF;
        if (branch && zero_flag) return (m_pc + int'(bimm)) & 16'hFFFF;
        return (m_pc + 1) & 16'hFFFF;
    endfunction

    task automatic model_commit();
        int npc;
        if (reset) begin
            m_pc = 0;
            m_stack.delete();
            m_err = 1'b0;
        end else if (pc_en) begin
            npc = model_next();
            if (ret) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
                else m_err = 1'b1;
            end else if (jal && link) begin
                m_stack.push_back((m_pc + 1) & 16'hFFFF);
                if (m_stack.size() > DEPTH) begin
                    void'(m_stack.pop_front());
                    m_err = 1'b1;
                end
            end
            m_pc = npc;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", 32'(pc), 32'(m_pc));
            chk("next_pc", 32'(next_pc), 32'(model_next()));
            chk("ras_empty", 32'(ras_empty), 32'(m_stack.size() == 0));
            chk("ras_full", 32'(ras_full), 32'(m_stack.size() == DEPTH));
            chk("ras_err", 32'(ras_err), 32'(m_err));
        end
    end

    // Apply inputs, take one clock edge, update the model with the same inputs.
    task automatic step(input bit rst, input bit en, input bit br, input bit z, input bit j,
                        input bit l, input bit r, input logic [15:0] ins);
        reset = rst; pc_en = en; branch = br; zero_flag = z;
        jal = j; link = l; ret = r; instruction = ins;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic plain();
        step(0, 1, 0, 0, 0, 0, 0, 16'h0000);
    endtask

    task automatic do_jal(input bit l, input logic [15:0] ins);
        step(0, 1, 0, 0, 1, l, 0, ins);
    endtask

    task automatic do_ret();
        step(0, 1, 0, 0, 0, 0, 1, 16'h0000);
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; pc_en = 1'b0; branch = 1'b0; zero_flag = 1'b0;
        jal = 1'b0; link = 1'b0; ret = 1'b0; instruction = '0;
        @(negedge clk);

        // 1: reset then sequential fetch
        do_reset();
        chk_en = 1'b1;
        chk("t1_reset_pc", 32'(pc), 32'h0);
        chk("t1_reset_empty", 32'(ras_empty), 32'h1);
        chk("t1_reset_err", 32'(ras_err), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            plain();
            chk("t1_seq_pc", 32'(pc), 32'(i));
        end

        // 2: BEQ taken / not taken at 0x0010
        do_reset();
        do_jal(0, 16'h0010);
        chk("t2_setup_pc", 32'(pc), 32'h10);
        step(0, 1, 1, 1, 0, 0, 0, 16'h003E);
        chk("t2_beq_taken", 32'(pc), 32'h0E);
        do_jal(0, 16'h0002);
        step(0, 1, 1, 0, 0, 0, 0, 16'h003E);
        chk("t2_beq_not_taken", 32'(pc), 32'h11);

        // 3: JAL+link then RET
        do_jal(0, 16'h000F);
        chk("t3_setup_pc", 32'(pc), 32'h20);
        do_jal(1, 16'h0010);
        chk("t3_jal_pc", 32'(pc), 32'h30);
        ret = 1'b1; #1;
        chk("t3_ras_top_preview", 32'(next_pc), 32'h21);
        do_ret();
        chk("t3_ret_pc", 32'(pc), 32'h21);
        chk("t3_ret_empty", 32'(ras_empty), 32'h1);

        // 4: overflow with five pushes, then four pops
        for (int i = 0; i < 5; i++) do_jal(1, 16'h0010);
        chk("t4_full", 32'(ras_full), 32'h1);
        chk("t4_err", 32'(ras_err), 32'h1);
        chk("t4_pc", 32'(pc), 32'h71);
        do_ret(); chk("t4_pop_e", 32'(pc), 32'h62);
        do_ret(); chk("t4_pop_d", 32'(pc), 32'h52);
        do_ret(); chk("t4_pop_c", 32'(pc), 32'h42);
        do_ret(); chk("t4_pop_b", 32'(pc), 32'h32);
        chk("t4_empty", 32'(ras_empty), 32'h1);

        // 5: underflow, hold with pc_en=0, reset mid-run
        do_reset();
        do_jal(0, 16'h0040);
        do_ret();
        chk("t5_underflow_pc", 32'(pc), 32'h41);
        chk("t5_underflow_err", 32'(ras_err), 32'h1);
        do_jal(1, 16'h0010);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 1, 0, 16'h0010);
        chk("t5_hold_pc", 32'(pc), 32'h51);
        chk("t5_hold_next_pc", 32'(next_pc), 32'h61);
        step(0, 0, 0, 0, 0, 0, 1, 16'h0000);
        chk("t5_hold_ret_pc", 32'(pc), 32'h51);
        do_reset();
        chk("t5_reset_pc", 32'(pc), 32'h0);
        chk("t5_reset_err", 32'(ras_err), 32'h0);
        chk("t5_reset_empty", 32'(ras_empty), 32'h1);
        do_ret();
        chk("t5_ret_after_reset", 32'(pc), 32'h1);

        // 6: wrap at 0xFFFF, and ret beats jal+link
        do_reset();
        do_jal(0, 16'h01FF);
        chk("t6_neg_jal", 32'(pc), 32'hFFFF);
        plain();
        chk("t6_wrap", 32'(pc), 32'h0);
        do_jal(1, 16'h0010);
        step(0, 1, 0, 0, 1, 1, 1, 16'h0010);
        chk("t6_ret_wins_pc", 32'(pc), 32'h1);
        chk("t6_ret_wins_empty", 32'(ras_empty), 32'h1);
        step(0, 1, 0, 0, 0, 1, 0, 16'h0010);
        chk("t6_link_no_jal", 32'(ras_empty), 32'h1);
        step(0, 1, 1, 1, 0, 0, 0, 16'h0020);
        chk("t6_beq_neg_max", 32'(pc), 32'hFFE2);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
